// File: rtl/instr_issue_ctrl.sv
// Round-robin write-port arbiter and in-order queue controller for the
// instruction register; the read side behaves as a FIFO with source tags.
module instr_issue_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 32,
  parameter int AW      = 5,
  parameter int OPC_W   = 4,
  parameter int OP_W    = 32,
  localparam int SW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*OPC_W-1:0] req_opcode,
  input  logic [NUM_REQ*OP_W-1:0]  req_operand_a,
  input  logic [NUM_REQ*OP_W-1:0]  req_operand_b,
  output logic                     load_en,
  output logic [AW-1:0]            write_pointer,
  output logic [OPC_W-1:0]         opcode,
  output logic [OP_W-1:0]          operand_a,
  output logic [OP_W-1:0]          operand_b,
  output logic [AW-1:0]            read_pointer,
  output logic                     rd_valid,
  input  logic                     rd_ack,
  output logic [SW-1:0]            rd_src,
  output logic [AW:0]              count,
  output logic                     full,
  output logic                     empty
);

  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, wp_q;
  logic [AW:0]      count_q, count_d;
  logic             load_q;
  logic [OPC_W-1:0] opc_q;
  logic [OP_W-1:0]  a_q, b_q;
  logic [SW-1:0]    rr_q, rr_d;
  logic [SW-1:0]    tag_mem [DEPTH];

  logic [AW+1:0]    occ;
  logic             space, gnt_vld, pop;
  logic [SW-1:0]    gnt, idx;

  // The landing still in flight is counted as occupied; a same-cycle pop is not.
  assign occ   = {1'b0, count_q} + (AW+2)'(load_q);
  assign space = occ < (AW+2)'(DEPTH);
  assign pop   = rd_ack & rd_valid;

  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    idx     = '0;
    if (space) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = SW'((int'(rr_q) + k) % NUM_REQ);
        if (!gnt_vld && req_valid[idx]) begin
          gnt_vld = 1'b1;
          gnt     = idx;
        end
      end
    end
  end

  assign req_ready = gnt_vld ? (NUM_REQ'(1) << gnt) : '0;
  assign count_d   = count_q + (AW+1)'(load_q) - (AW+1)'(pop);
  assign rr_d      = (gnt == SW'(NUM_REQ-1)) ? '0 : gnt + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_q   <= 1'b0;
      wp_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      opc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rr_q     <= '0;
    end else begin
      load_q  <= gnt_vld;
      count_q <= count_d;
      if (gnt_vld) begin
        opc_q    <= req_opcode[int'(gnt)*OPC_W +: OPC_W];
        a_q      <= req_operand_a[int'(gnt)*OP_W +: OP_W];
        b_q      <= req_operand_b[int'(gnt)*OP_W +: OP_W];
        wp_q     <= wr_ptr_q;
        wr_ptr_q <= wr_ptr_q + 1'b1;
        rr_q     <= rr_d;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Tags are not reset; rd_valid masks any stale entry.
  always_ff @(posedge clk) begin
    if (gnt_vld) tag_mem[wr_ptr_q] <= gnt;
  end

  assign load_en       = load_q;
  assign write_pointer = wp_q;
  assign opcode        = opc_q;
  assign operand_a     = a_q;
  assign operand_b     = b_q;
  assign read_pointer  = rd_ptr_q;
  assign count         = count_q;
  assign rd_valid      = (count_q != '0);
  assign full          = (count_q == (AW+1)'(DEPTH));
  assign empty         = (count_q == '0);
  assign rd_src        = tag_mem[rd_ptr_q];

endmodule

// File: tb/tb_instr_issue_ctrl.sv
// Bench for instr_issue_ctrl: queue-based model checked every cycle plus
// directed vectors with literal expectations.
module tb_instr_issue_ctrl;

  logic         clk, reset;
  logic [3:0]   req_valid, req_ready;
  logic [15:0]  req_opcode;
  logic [127:0] req_operand_a, req_operand_b;
  logic         load_en, rd_valid, rd_ack, full, empty;
  logic [4:0]   write_pointer, read_pointer;
  logic [3:0]   opcode;
  logic [31:0]  operand_a, operand_b;
  logic [1:0]   rd_src;
  logic [5:0]   count;

  instr_issue_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_operand_a(req_operand_a),
    .req_operand_b(req_operand_b), .load_en(load_en),
    .write_pointer(write_pointer), .opcode(opcode), .operand_a(operand_a),
    .operand_b(operand_b), .read_pointer(read_pointer), .rd_valid(rd_valid),
    .rd_ack(rd_ack), .rd_src(rd_src), .count(count), .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: queue of every accepted entry not yet popped; the newest one is
  // still in flight (not counted) for one cycle after its handshake.
  typedef struct { int src; logic [3:0] o; logic [31:0] a; logic [31:0] b; } ent_t;
  ent_t q[$];
  ent_t m_last;
  int   pend, m_rr, m_wr, m_rd, m_wp;
  int   glog[$];

  function automatic int egrant(logic [3:0] v, int c, int p, int rr);
    if (c + p >= 32) return -1;
    for (int k = 0; k < 4; k++)
      if (v[(rr + k) % 4]) return (rr + k) % 4;
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      pend = 0; m_rr = 0; m_wr = 0; m_rd = 0; m_wp = 0;
      m_last = '{0, 4'h0, 32'h0, 32'h0};
    end else begin
      int c, g;
      ent_t e;
      c = q.size() - pend;
      g = egrant(req_valid, c, pend, m_rr);
      if (rd_ack && c > 0) begin
        void'(q.pop_front());
        m_rd = (m_rd + 1) % 32;
      end
      pend = (g >= 0) ? 1 : 0;
      if (g >= 0) begin
        e = '{g, req_opcode[g*4 +: 4], req_operand_a[g*32 +: 32], req_operand_b[g*32 +: 32]};
        q.push_back(e);
        m_wp = m_wr;
        m_wr = (m_wr + 1) % 32;
        m_rr = (g + 1) % 4;
        m_last = e;
      end
    end
  end

  // External instruction register, written from values sampled mid-cycle.
  logic [31:0] mem_a [32];
  logic [3:0]  mem_o [32];
  logic        st_le;
  logic [4:0]  st_wp;
  logic [31:0] st_a;
  logic [3:0]  st_o;

  always @(posedge clk) if (st_le) begin
    mem_a[st_wp] <= st_a;
    mem_o[st_wp] <= st_o;
  end

  always @(negedge clk) begin
    st_le = 1'b0;
    if (!reset) begin
      int c, eg;
      st_le = load_en; st_wp = write_pointer; st_a = operand_a; st_o = opcode;
      c  = q.size() - pend;
      eg = egrant(req_valid, c, pend, m_rr);
      chk("req_ready", 64'(req_ready), (eg < 0) ? 64'h0 : (64'h1 << eg));
      chk("load_en", 64'(load_en), 64'(pend));
      chk("write_pointer", 64'(write_pointer), 64'(m_wp));
      chk("opcode", 64'(opcode), 64'(m_last.o));
      chk("operand_a", 64'(operand_a), 64'(m_last.a));
      chk("operand_b", 64'(operand_b), 64'(m_last.b));
      chk("read_pointer", 64'(read_pointer), 64'(m_rd));
      chk("count", 64'(count), 64'(c));
      chk("full", 64'(full), 64'(c == 32));
      chk("empty", 64'(empty), 64'(c == 0));
      chk("rd_valid", 64'(rd_valid), 64'(c != 0));
      if (c > 0) chk("rd_src", 64'(rd_src), 64'(q[0].src));
      if (c > 0 && rd_ack) begin
        chk("pop_a", 64'(mem_a[read_pointer]), 64'(q[0].a));
        chk("pop_opc", 64'(mem_o[read_pointer]), 64'(q[0].o));
      end
      for (int i = 0; i < 4; i++) if (req_valid[i] && req_ready[i]) glog.push_back(i);
    end
  end

  int seq = 0;
  int nxfer = 0;

  task automatic set_req(input int i, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    req_opcode[i*4 +: 4]     = o;
    req_operand_a[i*32 +: 32] = a;
    req_operand_b[i*32 +: 32] = b;
  endtask

  task automatic new_data(input int i);
    seq++;
    set_req(i, 4'(seq), 32'(1000 * (i + 1) + seq), 32'(-seq));
  endtask

  task automatic step(input logic [3:0] vm, input logic ack);
    logic [3:0] xf;
    req_valid = vm; rd_ack = ack;
    @(negedge clk);
    xf = req_valid & req_ready;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) if (xf[i]) begin new_data(i); nxfer++; end
  endtask

  task automatic reset_mid;
    @(posedge clk); #3;
    reset = 1'b1; req_valid = '0; rd_ack = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_load_en", 64'(load_en), 64'd0);
    chk("rst_wp", 64'(write_pointer), 64'd0);
    chk("rst_rp", 64'(read_pointer), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    glog.delete();
    nxfer = 0;
  endtask

  task automatic drain;
    int cyc = 0;
    while (q.size() != 0 && cyc < 100) begin step(4'h0, 1'b1); cyc++; end
    chk("drain_done", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int exp2 [12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 3, 0};
    int cyc;
    reset = 1'b1; req_valid = '0; rd_ack = 1'b0;
    for (int i = 0; i < 4; i++) new_data(i);
    @(posedge clk); #1; reset = 1'b0;

    // 1: reset with traffic active, then a single transaction
    for (int i = 0; i < 3; i++) step(4'hF, 1'b0);
    reset_mid();
    set_req(1, 4'd3, 32'd5, 32'd7);
    req_valid = 4'b0010;
    @(negedge clk); chk("t1_ready", 64'(req_ready), 64'b0010);
    @(posedge clk); #1; req_valid = '0;
    @(negedge clk);
    chk("t1_load_en", 64'(load_en), 64'd1);
    chk("t1_wp", 64'(write_pointer), 64'd0);
    chk("t1_a", 64'(operand_a), 64'd5);
    chk("t1_b", 64'(operand_b), 64'd7);
    chk("t1_opc", 64'(opcode), 64'd3);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_count", 64'(count), 64'd1);
    chk("t1_rd_valid", 64'(rd_valid), 64'd1);
    chk("t1_rd_src", 64'(rd_src), 64'd1);
    @(posedge clk); #1;

    // 2: round-robin rotation, then restricted requesters from rr_ptr=2
    reset_mid();
    for (int i = 0; i < 10; i++) step(4'hF, 1'b0);
    for (int i = 0; i < 2; i++) step(4'b1001, 1'b0);
    chk("t2_nlog", 64'(glog.size()), 64'd12);
    for (int i = 0; i < 12 && i < glog.size(); i++) chk($sformatf("t2_grant%0d", i), 64'(glog[i]), 64'(exp2[i]));

    // 3: fill to 32, stall, single pop resumes granting
    reset_mid();
    cyc = 0;
    while (nxfer < 32 && cyc < 40) begin step(4'hF, 1'b0); cyc++; end
    chk("t3_nxfer", 64'(nxfer), 64'd32);
    req_valid = 4'hF;
    @(negedge clk);
    chk("t3_ready_pend", 64'(req_ready), 64'd0);
    chk("t3_count31", 64'(count), 64'd31);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t3_full", 64'(full), 64'd1);
    chk("t3_ready_full", 64'(req_ready), 64'd0);
    @(posedge clk); #1; rd_ack = 1'b1;
    @(posedge clk); #1; rd_ack = 1'b0; req_valid = '0;
    @(negedge clk);
    chk("t3_count_pop", 64'(count), 64'd31);
    chk("t3_full_pop", 64'(full), 64'd0);
    req_valid = 4'hF;
    #1 chk("t3_resume", 64'(req_ready), 64'b0001);
    @(posedge clk); #1; new_data(0); req_valid = '0;
    drain();

    // 4: 40 pushes with alternate pops; both pointers wrap
    reset_mid();
    cyc = 0;
    while (nxfer < 40 && cyc < 200) begin step(4'hF, 1'(cyc % 2)); cyc++; end
    chk("t4_nxfer", 64'(nxfer), 64'd40);
    drain();
    step(4'h0, 1'b0);
    chk("t4_wp", 64'(write_pointer), 64'd7);
    chk("t4_rp", 64'(read_pointer), 64'd8);
    chk("t4_empty", 64'(empty), 64'd1);

    // 5: landing and pop on the same edge; pop while empty
    reset_mid();
    cyc = 0;
    while (nxfer < 5 && cyc < 20) begin step(4'b0001, 1'b0); cyc++; end
    step(4'h0, 1'b0); step(4'h0, 1'b0);
    step(4'b0001, 1'b0);
    req_valid = '0; rd_ack = 1'b1;
    @(negedge clk);
    chk("t5_load_en", 64'(load_en), 64'd1);
    chk("t5_count_pre", 64'(count), 64'd5);
    @(posedge clk); #1; rd_ack = 1'b0;
    @(negedge clk);
    chk("t5_count_post", 64'(count), 64'd5);
    @(posedge clk); #1;
    drain();
    step(4'h0, 1'b1);
    step(4'h0, 1'b0);
    chk("t5_rp_empty", 64'(read_pointer), 64'd6);
    chk("t5_count0", 64'(count), 64'd0);

    // 6: requester 2 withdraws before being granted
    reset_mid();
    step(4'b0101, 1'b0);
    step(4'b0001, 1'b0);
    step(4'h0, 1'b0);
    chk("t6_nlog", 64'(glog.size()), 64'd2);
    if (glog.size() == 2) begin
      chk("t6_g0", 64'(glog[0]), 64'd0);
      chk("t6_g1", 64'(glog[1]), 64'd0);
    end
    chk("t6_rd_src", 64'(rd_src), 64'd0);
    chk("t6_count", 64'(count), 64'd2);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_issue_ctrl.md
Name: instr_issue_ctrl

Overview:
Round-robin write-port arbiter and in-order queue controller for the 32-entry instruction register. Up to NUM_REQ requesters submit opcode/operand_a/operand_b transactions. The block drives the register's load_en, write_pointer and write data, and assigns addresses sequentially. The read side manages read_pointer so the register behaves as a FIFO toward a single consumer, with the source requester tag returned alongside each entry.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DEPTH, 32, instruction register entries (power of two)
AW, 5, address width, log2(DEPTH)
OPC_W, 4, opcode width
OP_W, 32, operand width (signed)

Ports:
clk  in  1  clock, rising-edge
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester transaction valid
req_ready  out  NUM_REQ  per-requester grant, one-hot or zero
req_opcode  in  NUM_REQ*OPC_W  packed opcodes; requester i at [i*OPC_W +: OPC_W]
req_operand_a  in  NUM_REQ*OP_W  packed operand_a
req_operand_b  in  NUM_REQ*OP_W  packed operand_b
load_en  out  1  instruction register write enable
write_pointer  out  AW  instruction register write address
opcode  out  OPC_W  write data, opcode
operand_a  out  OP_W  write data, operand_a
operand_b  out  OP_W  write data, operand_b
read_pointer  out  AW  instruction register read address; read port is combinational
rd_valid  out  1  entry at read_pointer is valid
rd_ack  in  1  consumer pops the head entry
rd_src  out  log2(NUM_REQ)  requester index that wrote the head entry
count  out  AW+1  occupied entries, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- Reset (async, immediate): load_en=0, write_pointer=0, read_pointer=0, opcode/operand_a/operand_b=0, count=0, full=0, empty=1, rd_valid=0, rr_ptr=0, internal wr_ptr=0. The instruction register contents are not cleared. Stale entries are never exposed because rd_valid=0.
- Space check: space = (count + load_en) < DEPTH. Pending landings are counted; a same-cycle pop is not credited.
- Arbitration: combinational. If space is true, grant the first i with req_valid[i]=1, searching from rr_ptr upward modulo NUM_REQ. req_ready is one-hot on the granted requester, otherwise all zero.
- Handshake: transfer occurs when req_valid[i] & req_ready[i]. Requesters hold valid and data stable until ready. Withdrawing valid without a transfer is legal.
- On a transfer at edge T:
  - Capture the granted requester's data into opcode/operand_a/operand_b.
  - write_pointer<=wr_ptr; load_en<=1.
  - wr_ptr<=wr_ptr+1, wrapping at DEPTH-1 to 0.
  - rr_ptr<=grant+1 mod NUM_REQ.
  - tag_mem[wr_ptr]<=grant.
- With no transfer: load_en<=0; write data and write_pointer hold their values.
- Latency: handshake at edge T, load_en high during T..T+1, register captures the entry at edge T+1, and the entry is counted from edge T+1. Minimum handshake-to-rd_valid latency is 2 cycles.
- Count update per edge: count <= count + load_en - pop, where pop = rd_ack & rd_valid.
  - A landing and a pop on the same edge leave count unchanged.
  - rd_ack while empty is ignored.
- Read side: rd_valid = (count != 0), registered via count. rd_src = tag_mem[read_pointer]. On pop, read_pointer<=read_pointer+1, wrapping at DEPTH.
- full and empty are decoded from registered count. While full or full-pending, req_ready=0.
- Throughput: one write per cycle sustained. A full queue resumes granting in the cycle after a pop lowers count.
- Ordering: strict FIFO across all requesters, in grant order.

Test Plan:
1. Assert reset mid-cycle with traffic active -> all outputs immediately at reset values (count=0, empty=1, rd_valid=0, load_en=0). Release reset, then req_valid[1] with opc=3, a=5, b=7 -> req_ready=4'b0010 same cycle. Next cycle: load_en=1, write_pointer=0, operand_a=5, operand_b=7, opcode=3. One cycle later: count=1, rd_valid=1, rd_src=1.
2. All 4 requesters held valid for 8 cycles -> grants 0,1,2,3,0,1,2,3 and write_pointer 0..7. After rr_ptr=2, raising only req_valid[0] and req_valid[3] -> grant 3, then 0.
3. Push 32 entries with no pops -> after the 32nd handshake, req_ready=0 while valid is held; full=1 one cycle later. Single rd_ack -> count=31, and a grant occurs the following cycle.
4. Push 40 entries with a rd_ack every other cycle -> write_pointer wraps 31 to 0, read_pointer wraps likewise. Popped operand_a sequence matches push order exactly, with no loss or duplication.
5. A landing (load_en=1) and rd_ack on the same edge with count=5 -> count stays 5. rd_ack with count=0 -> no pointer change.
6. Requester drops valid before a grant while another is valid -> no transfer is recorded for the dropped requester, and rd_src of every entry matches the actual writer.
